// File: rtl/seq_table.sv
// seq_table: lookup table that self-fills with base + i*step (mod 2^DATA_W),
// supports run-time re-fill, single-entry writes and a registered read port.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   init_req, base_in, step_in  re-fill request (taken only when ready)
//   ready                       table filled, port accepts reads/writes
//   rd_en, rd_addr              read request
//   rd_valid, rd_data, rd_err   registered read result (1-cycle pulse)
//   wr_en, wr_addr, wr_data     single-entry write
module seq_table #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3,
  parameter int unsigned INIT_BASE = 0,
  parameter int unsigned INIT_STEP = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init_req,
  input  logic [DATA_W-1:0] base_in,
  input  logic [DATA_W-1:0] step_in,
  output logic              ready,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_err,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  typedef enum logic {
    FILL,
    READY
  } state_t;

  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0] DEPTH_L =
    (ADDR_W + 1)'(DEPTH);
  localparam logic [DATA_W-1:0] BASE0 =
    DATA_W'(INIT_BASE);
  localparam logic [DATA_W-1:0] STEP0 =
    DATA_W'(INIT_STEP);

  state_t            state;
  state_t            state_nx;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] idx_nx;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] acc_nx;
  logic [DATA_W-1:0] step;
  logic [DATA_W-1:0] step_nx;
  logic              fill_we;

  logic [DATA_W-1:0] mem [DEPTH];

  logic accept;
  logic rd_go;
  logic rd_in;
  logic wr_go;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FILL;
      idx   <= '0;
      acc   <= BASE0;
      step  <= STEP0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
      acc   <= acc_nx;
      step  <= step_nx;
    end
  end

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    acc_nx   = acc;
    step_nx  = step;
    fill_we  = 1'b0;
    unique case (state)
      FILL: begin
        fill_we = 1'b1;
        acc_nx  = acc + step;
        idx_nx  = idx + 1'b1;
        if (idx == LAST) begin
          idx_nx   = '0;
          state_nx = READY;
        end
      end
      READY: begin
        if (init_req) begin
          acc_nx   = base_in;
          step_nx  = step_in;
          idx_nx   = '0;
          state_nx = FILL;
        end
      end
      default: state_nx = FILL;
    endcase
  end

  assign ready  = (state == READY);
  // a re-fill request wins over any access in the same cycle
  assign accept = ready & ~init_req;
  assign rd_go  = accept & rd_en;
  assign rd_in  = ({1'b0, rd_addr} < DEPTH_L);
  assign wr_go  = accept & wr_en &
                  ({1'b0, wr_addr} < DEPTH_L);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (fill_we) begin
      mem[idx] <= acc;
    end else if (wr_go) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // storage is read on the same edge it is written,
  // so a colliding read returns the old entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_err   <= 1'b0;
    end else begin
      rd_valid <= rd_go;
      if (rd_go) begin
        if (rd_in) begin
          rd_data <= mem[rd_addr];
          rd_err  <= 1'b0;
        end else begin
          rd_data <= '0;
          rd_err  <= 1'b1;
        end
      end
    end
  end

endmodule
